// File: rtl/nibble_seq_matcher_pkg.sv
// Shared types and constants for the nibble sequence matcher.
// The MATCH_COUNT_EN build option uses MATCH_CNT_W/MATCH_CNT_MAX.
package nibble_seq_matcher_pkg;

    localparam int unsigned NIBBLE_W = 4;
    typedef logic [NIBBLE_W-1:0] nibble_t;

    localparam int unsigned MATCH_CNT_W = 8;
    localparam logic [MATCH_CNT_W-1:0] MATCH_CNT_MAX = 8'd255;

    function automatic int unsigned idx_w(input int unsigned key_len);
        return (key_len <= 1) ? 1 : $clog2(key_len);
    endfunction

endpackage

// File: rtl/nibble_seq_matcher_if.sv
// Stream/key/result bundle for nibble_seq_matcher.
// match_count is present only when MATCH_COUNT_EN is defined.
interface nibble_seq_matcher_if #(
    parameter int unsigned KEY_LEN = 4
);
    localparam int unsigned IDX_W = nibble_seq_matcher_pkg::idx_w(KEY_LEN);

    logic                    key_load;
    logic [4*KEY_LEN-1:0]    key_in;
    nibble_seq_matcher_pkg::nibble_t din;
    logic                    din_valid;
    logic                    match;
    logic [IDX_W-1:0]        progress;
`ifdef MATCH_COUNT_EN
    logic [nibble_seq_matcher_pkg::MATCH_CNT_W-1:0] match_count;
`endif

    modport master (
        output key_load, key_in, din, din_valid,
        input  match, progress
`ifdef MATCH_COUNT_EN
        , input match_count
`endif
    );

    modport slave (
        input  key_load, key_in, din, din_valid,
        output match, progress
`ifdef MATCH_COUNT_EN
        , output match_count
`endif
    );

endinterface

// File: rtl/nibble_seq_matcher_comp4.sv
// comp4: 4-bit unsigned equality comparator.
module comp4 (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    output logic       eq_o
);

    assign eq_o = (a_i == b_i);

endmodule

// File: rtl/nibble_seq_matcher.sv
// Streaming nibble sequence detector with simple-restart (non-KMP) matching.
// Define MATCH_COUNT_EN to add the saturating match_count output.
module nibble_seq_matcher
    import nibble_seq_matcher_pkg::*;
#(
    parameter int unsigned KEY_LEN = 4
) (
    input  logic clk,
    input  logic rst_n,
    nibble_seq_matcher_if.slave bus
);

    localparam int unsigned IDX_W = idx_w(KEY_LEN);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(KEY_LEN - 1);

    logic [4*KEY_LEN-1:0] key_q, key_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 match_q, match_d;
    nibble_t              key_nib [KEY_LEN];
    nibble_t              key_cur;
    logic                 eq_cur, eq_first;

    for (genvar g = 0; g < KEY_LEN; g++) begin : g_nib
        assign key_nib[g] = key_q[g*NIBBLE_W +: NIBBLE_W];
    end

    always_comb begin
        key_cur = key_nib[0];
        for (int unsigned i = 0; i < KEY_LEN; i++) begin
            if (idx_q == IDX_W'(i)) key_cur = key_nib[i];
        end
    end

    comp4 u_comp_cur (
        .a_i  (bus.din),
        .b_i  (key_cur),
        .eq_o (eq_cur)
    );

    comp4 u_comp_first (
        .a_i  (bus.din),
        .b_i  (key_nib[0]),
        .eq_o (eq_first)
    );

    always_comb begin
        key_d   = key_q;
        idx_d   = idx_q;
        match_d = 1'b0;
        if (bus.key_load) begin
            key_d = bus.key_in;
            idx_d = '0;
        end else if (bus.din_valid) begin
            if (eq_cur) begin
                if (idx_q == IDX_LAST) begin
                    match_d = 1'b1;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end else begin
                // Restart: only a one-nibble prefix is recovered.
                idx_d = eq_first ? IDX_W'(1) : '0;
            end
        end
    end

`ifdef MATCH_COUNT_EN
    logic [MATCH_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (bus.key_load) begin
            cnt_d = '0;
        end else if (match_d && (cnt_q != MATCH_CNT_MAX)) begin
            cnt_d = cnt_q + MATCH_CNT_W'(1);
        end
    end

    assign bus.match_count = cnt_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q   <= '0;
            idx_q   <= '0;
            match_q <= 1'b0;
`ifdef MATCH_COUNT_EN
            cnt_q   <= '0;
`endif
        end else begin
            key_q   <= key_d;
            idx_q   <= idx_d;
            match_q <= match_d;
`ifdef MATCH_COUNT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign bus.match    = match_q;
    assign bus.progress = idx_q;

endmodule

// File: tb/tb_nibble_seq_matcher.sv
// Directed table-driven bench for nibble_seq_matcher (KEY_LEN=4 and KEY_LEN=1 instances).
// Counter checks are active when MATCH_COUNT_EN is defined.
module tb_nibble_seq_matcher;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;

    nibble_seq_matcher_if #(.KEY_LEN(4)) bus4 ();
    nibble_seq_matcher_if #(.KEY_LEN(1)) bus1 ();

    nibble_seq_matcher #(.KEY_LEN(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    nibble_seq_matcher #(.KEY_LEN(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        kl;
        logic [15:0] ki;
        logic [3:0]  din;
        logic        dv;
        logic        exp_match;
        int          exp_prog;
        int          exp_cnt;
    } vec_t;

    vec_t vecs [30];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive4(input logic kl, input logic [15:0] ki, input logic [3:0] d,
                          input logic dv);
        bus4.key_load  = kl;
        bus4.key_in    = ki;
        bus4.din       = d;
        bus4.din_valid = dv;
    endtask

    task automatic drive1(input logic kl, input logic [3:0] ki, input logic [3:0] d,
                          input logic dv);
        bus1.key_load  = kl;
        bus1.key_in    = ki;
        bus1.din       = d;
        bus1.din_valid = dv;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_vec(input int i, input logic kl, input logic [15:0] ki,
                           input logic [3:0] d, input logic dv, input logic m,
                           input int p, input int c);
        vecs[i].kl        = kl;
        vecs[i].ki        = ki;
        vecs[i].din       = d;
        vecs[i].dv        = dv;
        vecs[i].exp_match = m;
        vecs[i].exp_prog  = p;
        vecs[i].exp_cnt   = c;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;

        // Exact hit
        set_vec(0,  1, 16'h9A57, 4'h0, 0, 0, 0, 0);
        set_vec(1,  0, 16'h0,    4'h7, 1, 0, 1, 0);
        set_vec(2,  0, 16'h0,    4'h5, 1, 0, 2, 0);
        set_vec(3,  0, 16'h0,    4'hA, 1, 0, 3, 0);
        set_vec(4,  0, 16'h0,    4'h9, 1, 1, 0, 1);
        set_vec(5,  0, 16'h0,    4'h0, 0, 0, 0, 1);
        // Restart via eq_first: 7,5,7,5,A,9
        set_vec(6,  0, 16'h0,    4'h7, 1, 0, 1, 1);
        set_vec(7,  0, 16'h0,    4'h5, 1, 0, 2, 1);
        set_vec(8,  0, 16'h0,    4'h7, 1, 0, 1, 1);
        set_vec(9,  0, 16'h0,    4'h5, 1, 0, 2, 1);
        set_vec(10, 0, 16'h0,    4'hA, 1, 0, 3, 1);
        set_vec(11, 0, 16'h0,    4'h9, 1, 1, 0, 2);
        // Restart to zero: 7,5,3
        set_vec(12, 0, 16'h0,    4'h7, 1, 0, 1, 2);
        set_vec(13, 0, 16'h0,    4'h5, 1, 0, 2, 2);
        set_vec(14, 0, 16'h0,    4'h3, 1, 0, 0, 2);
        // Gap of two idle cycles
        set_vec(15, 0, 16'h0,    4'h7, 1, 0, 1, 2);
        set_vec(16, 0, 16'h0,    4'h5, 0, 0, 1, 2);
        set_vec(17, 0, 16'h0,    4'hA, 0, 0, 1, 2);
        set_vec(18, 0, 16'h0,    4'h5, 1, 0, 2, 2);
        set_vec(19, 0, 16'h0,    4'hA, 1, 0, 3, 2);
        set_vec(20, 0, 16'h0,    4'h9, 1, 1, 0, 3);
        // key_load beats the final nibble
        set_vec(21, 0, 16'h0,    4'h7, 1, 0, 1, 3);
        set_vec(22, 0, 16'h0,    4'h5, 1, 0, 2, 3);
        set_vec(23, 0, 16'h0,    4'hA, 1, 0, 3, 3);
        set_vec(24, 1, 16'h1111, 4'h9, 1, 0, 0, 0);
        set_vec(25, 0, 16'h0,    4'h1, 1, 0, 1, 0);
        set_vec(26, 0, 16'h0,    4'h1, 1, 0, 2, 0);
        set_vec(27, 0, 16'h0,    4'h1, 1, 0, 3, 0);
        set_vec(28, 0, 16'h0,    4'h1, 1, 1, 0, 1);
        set_vec(29, 0, 16'h0,    4'h1, 0, 0, 0, 1);

        rst_n = 1'b0;
        drive4(0, 16'h0, 4'h0, 0);
        drive1(0, 4'h0, 4'h0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_match", int'(bus4.match), 0);
        check("reset_progress", int'(bus4.progress), 0);
        check("reset_match_k1", int'(bus1.match), 0);
`ifdef MATCH_COUNT_EN
        check("reset_count", int'(bus4.match_count), 0);
`endif
        rst_n = 1'b1;

        for (int i = 0; i < 30; i++) begin
            drive4(vecs[i].kl, vecs[i].ki, vecs[i].din, vecs[i].dv);
            tick();
            check($sformatf("vec%0d_match", i), int'(bus4.match), int'(vecs[i].exp_match));
            check($sformatf("vec%0d_progress", i), int'(bus4.progress), vecs[i].exp_prog);
`ifdef MATCH_COUNT_EN
            check($sformatf("vec%0d_count", i), int'(bus4.match_count), vecs[i].exp_cnt);
`endif
        end

        // Async reset mid-sequence
        drive4(1, 16'h9A57, 4'h0, 0);
        tick();
        drive4(0, 16'h0, 4'h7, 1);
        tick();
        drive4(0, 16'h0, 4'h5, 1);
        tick();
        drive4(0, 16'h0, 4'hA, 1);
        tick();
        check("pre_reset_progress", int'(bus4.progress), 3);
        drive4(0, 16'h0, 4'h0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_progress", int'(bus4.progress), 0);
        check("async_reset_match", int'(bus4.match), 0);
        #1;
        rst_n = 1'b1;
        drive4(0, 16'h0, 4'h9, 1);
        tick();
        check("post_reset_9_match", int'(bus4.match), 0);
        check("post_reset_9_progress", int'(bus4.progress), 0);
        // Cleared key is all zeros, so a 0 nibble matches position 0
        drive4(0, 16'h0, 4'h0, 1);
        tick();
        check("post_reset_0_progress", int'(bus4.progress), 1);
        drive4(0, 16'h0, 4'h0, 0);

        // KEY_LEN=1: back-to-back matches and counter saturation
        drive1(1, 4'h3, 4'h0, 0);
        tick();
        check("k1_load_match", int'(bus1.match), 0);
        for (int k = 1; k <= 260; k++) begin
            drive1(0, 4'h0, 4'h3, 1);
            tick();
            check($sformatf("k1_match_%0d", k), int'(bus1.match), 1);
            check($sformatf("k1_progress_%0d", k), int'(bus1.progress), 0);
`ifdef MATCH_COUNT_EN
            check($sformatf("k1_count_%0d", k), int'(bus1.match_count), (k > 255) ? 255 : k);
`endif
        end
        drive1(0, 4'h0, 4'h4, 1);
        tick();
        check("k1_miss_match", int'(bus1.match), 0);
`ifdef MATCH_COUNT_EN
        check("k1_count_held", int'(bus1.match_count), 255);
`endif
        drive1(1, 4'h3, 4'h3, 1);
        tick();
        check("k1_load_priority_match", int'(bus1.match), 0);
`ifdef MATCH_COUNT_EN
        check("k1_count_cleared", int'(bus1.match_count), 0);
`endif
        drive1(0, 4'h0, 4'h0, 0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/nibble_seq_matcher.md
Name: nibble_seq_matcher

Overview:
- Streaming sequence detector that consumes 4-bit nibbles and flags when the last KEY_LEN accepted nibbles equal a programmable key.
- Sits directly downstream of the team's 4-bit equality comparator (comp4) and instantiates it to produce per-nibble equality.
- Drives single-cycle match pulses to the control logic above it.

Parameters:
- KEY_LEN, 4, number of nibbles in the key (>=1).
- Localparam IDX_W = max(1, $clog2(KEY_LEN)); width of the position index.

Ports:
- clk  in  1  single clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- key_load  in  1  load key_in into the key register this cycle.
- key_in  in  4*KEY_LEN  new key; nibble 0 = bits [3:0] = first expected nibble.
- din  in  4  stream nibble.
- din_valid  in  1  din is accepted this cycle.
- match  out  1  one-cycle pulse; the full key was just received.
- progress  out  IDX_W  number of key nibbles currently matched (idx).
- match_count  out  8  saturating match counter (only with MATCH_COUNT_EN).

Behaviour:
- Reset (async, rst_n=0): key_reg=0, idx=0, match=0, match_count=0. Takes effect immediately; a partial match is discarded.
- Key load: on key_load=1, key_reg<=key_in and idx<=0. No match pulse is produced that cycle. key_load has priority over din_valid, so din is ignored in the same cycle.
- Hold: din_valid=0 and key_load=0 leaves idx unchanged and sets match=0.
- Accept (din_valid=1, key_load=0):
  - eq_cur = (din == key_reg nibble[idx]); eq_first = (din == key_reg nibble[0]).
  - eq_cur and idx==KEY_LEN-1: match<=1 next cycle, idx<=0. Detection is non-overlapping.
  - eq_cur and idx<KEY_LEN-1: idx<=idx+1.
  - !eq_cur: idx<=eq_first ? 1 : 0. This is simple restart, not full KMP. A prefix longer than one nibble is not recovered.
- Exception for KEY_LEN=1: every accepted nibble equal to the key pulses match, and idx stays 0.
- match is registered. Latency is one cycle from the edge accepting the last key nibble, and the pulse is exactly one cycle wide. Back-to-back matches with KEY_LEN=1 give consecutive high cycles.
- progress = idx, registered, and is never observed equal to KEY_LEN.
- Equality is unsigned bitwise compare of 4-bit values. X-free: all registers are reset.

Optional Feature:
- Macro: MATCH_COUNT_EN.
- Defined:
  - Port match_count[7:0] exists and increments on each match pulse.
  - Saturates at 255.
  - Cleared to 0 by reset and by key_load.
  - If a match and key_load coincide, key_load wins and the count is 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package:
  - NIBBLE_W=4.
  - nibble_t typedef.
  - MATCH_CNT_W=8 and MATCH_CNT_MAX=255 constants.
  - Helper function for IDX_W.
- Sub-module: reuse existing comp4, instantiated twice. One instance compares din with nibble[idx]; the other compares din with nibble[0].
- idx/match/counter logic is a single always_ff; key-nibble select is a combinational mux.

Test Plan (KEY_LEN=4 unless noted):
- Reset then load: rst_n low 3 cycles, then key_load with key_in=16'h9A57. Expect match=0, progress=0, match_count=0.
- Exact hit: din 7,5,A,9 with valid on consecutive cycles. Expect progress 1,2,3,0 and match high exactly one cycle after 9 is accepted; match_count=1.
- Restart on mismatch:
  - Stream 7,5,7,5,A,9: the third nibble (7) mismatches, so progress goes to 1 (eq_first); one match follows the final 9.
  - Stream 7,5,3: progress goes to 0, no match.
- Gaps and priority:
  - 7,(valid=0 for 2 cycles),5,A,9: progress holds across the gap and match fires.
  - Assert key_load=16'h1111 in the same cycle as the final 9: no match, progress=0.
  - Then 1,1,1,1: match.
- Async reset mid-sequence: after 7,5,A, drop rst_n asynchronously between edges. Expect progress=0 and key=0 immediately; the following 9 produces no match.
- MATCH_COUNT_EN saturation, KEY_LEN=1, key=4'h3: 260 consecutive din=3 gives a match every cycle and match_count stops at 255. A subsequent key_load clears it to 0.
